// File: rtl/dda_pkg.sv
// dda_pkg: state type plus sizing and magnitude helpers shared by dda_multi_axis and dda_axis
package dda_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic int slot_w(input int slots);
    return slots > 1 ? $clog2(slots) : 1;
  endfunction
  function automatic int acc_w(input int slots);
    return $clog2(2 * slots);
  endfunction
  function automatic longint mag_of(input longint v);
    return v < 0 ? -v : v;
  endfunction
  function automatic longint clamp(input longint m, input longint lim);
    return m > lim ? lim : m;
  endfunction
endpackage

// File: rtl/dda_axis.sv
// dda_axis: one DDA channel with active/shadow command, step/dir outputs; POS_COUNT_EN adds a position counter
module dda_axis
  import dda_pkg::*;
#(
  parameter int CMD_W = 16,
  parameter int SLOTS = 2500
`ifdef POS_COUNT_EN
  , parameter int POS_W = 32
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [CMD_W-1:0] cmd,
  input  logic             wr_sh,
  input  logic             load_cmd,
  input  logic             load_sh,
  input  logic             tick,
  input  logic             slot_end,
  output logic             pulse,
  output logic             dir,
  output logic             sat_err
`ifdef POS_COUNT_EN
  , output logic [POS_W-1:0] pos
`endif
);
  localparam int AW = acc_w(SLOTS);
  logic [AW-1:0] acc, mag, sh_mag, cm, sum;
  logic sh_sign, csat, carry;
  longint am;
  assign am = mag_of(longint'(signed'(cmd)));
  assign csat = am > longint'(SLOTS);
  assign cm = AW'(clamp(am, longint'(SLOTS)));
  assign sum = acc + mag;
  assign carry = tick && sum >= AW'(SLOTS);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      acc <= '0;
      mag <= '0;
      sh_mag <= '0;
      sh_sign <= 1'b0;
      dir <= 1'b0;
      pulse <= 1'b0;
      sat_err <= 1'b0;
    end else begin
      if (wr_sh) begin
        sh_mag <= cm;
        sh_sign <= cmd[CMD_W-1];
      end
      if (load_cmd) begin
        mag <= cm;
        dir <= cmd[CMD_W-1];
        acc <= '0;
      end else if (load_sh) begin
        mag <= sh_mag;
        dir <= sh_sign;
        acc <= '0;
      end else if (tick)
        acc <= carry ? sum - AW'(SLOTS) : sum;
      pulse <= carry ? 1'b1 : slot_end ? 1'b0 : pulse;
      sat_err <= sat_err | ((wr_sh | load_cmd) & csat);
    end
`ifdef POS_COUNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pos <= '0;
    else if (carry) pos <= dir ? pos - POS_W'(1) : pos + POS_W'(1);
`endif
endmodule

// File: rtl/dda_multi_axis.sv
// dda_multi_axis: multi-axis DDA step/dir generator with shared slot timing; POS_COUNT_EN exposes per-axis positions
module dda_multi_axis
  import dda_pkg::*;
#(
  parameter int N_AXES  = 3,
  parameter int CMD_W   = 16,
  parameter int CLK_DIV = 40,
  parameter int SLOTS   = 2500
`ifdef POS_COUNT_EN
  , parameter int POS_W = 32
`endif
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_AXES*CMD_W-1:0] cmd_data,
  input  logic                    cmd_wr,
  output logic [N_AXES-1:0]       pulse,
  output logic [N_AXES-1:0]       dir,
  output logic                    busy,
  output logic                    period_done,
  output logic                    overrun,
  output logic [N_AXES-1:0]       sat_err
`ifdef POS_COUNT_EN
  , output logic [N_AXES*POS_W-1:0] pos
`endif
);
  localparam int PW = $clog2(2 * CLK_DIV);
  localparam int SW = slot_w(SLOTS);
  state_t state, state_n;
  logic [PW-1:0] ph;
  logic [SW-1:0] slot;
  logic pending, run, tick, end_slot, end_per, load_cmd, load_sh, wr_sh;
  assign run = state == RUN;
  assign busy = run;
  assign tick = run && ph == PW'(CLK_DIV - 1);
  assign end_slot = run && ph == PW'(2 * CLK_DIV - 1);
  assign end_per = end_slot && slot == SW'(SLOTS - 1);
  assign load_cmd = cmd_wr && (!run || end_per);
  assign load_sh = end_per && pending && !cmd_wr;
  assign wr_sh = cmd_wr && run && !end_per;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = !run ? (cmd_wr ? RUN : IDLE) : (end_per && !cmd_wr && !pending) ? IDLE : RUN;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ph <= '0;
      slot <= '0;
      pending <= 1'b0;
      overrun <= 1'b0;
      period_done <= 1'b0;
    end else begin
      ph <= (run && !end_slot) ? ph + PW'(1) : '0;
      slot <= (!run || end_per) ? '0 : end_slot ? slot + SW'(1) : slot;
      pending <= end_per ? 1'b0 : pending | wr_sh;
      overrun <= overrun | (wr_sh & pending);
      period_done <= end_per;
    end
  for (genvar g = 0; g < N_AXES; g++) begin : g_axis
    dda_axis #(
      .CMD_W(CMD_W),
      .SLOTS(SLOTS)
`ifdef POS_COUNT_EN
      , .POS_W(POS_W)
`endif
    ) u_axis (
      .clk(clk),
      .rst_n(rst_n),
      .cmd(cmd_data[g*CMD_W +: CMD_W]),
      .wr_sh(wr_sh),
      .load_cmd(load_cmd),
      .load_sh(load_sh),
      .tick(tick),
      .slot_end(end_slot),
      .pulse(pulse[g]),
      .dir(dir[g]),
      .sat_err(sat_err[g])
`ifdef POS_COUNT_EN
      , .pos(pos[g*POS_W +: POS_W])
`endif
    );
  end
endmodule

// File: tb/tb_dda_multi_axis.sv
// tb_dda_multi_axis: directed scoreboard bench for dda_multi_axis (CLK_DIV=2, SLOTS=10, 2 axes; POS_COUNT_EN adds position checks)
module tb_dda_multi_axis;
  typedef struct {int c0; int c1; logic d0; logic d1;} exp_t;
  logic clk = 1'b0, rst_n, cmd_wr;
  logic [31:0] cmd_data;
  logic [1:0] pulse, dir, sat_err;
  logic busy, period_done, overrun;
`ifdef POS_COUNT_EN
  logic [63:0] pos;
`endif
  int errors = 0, checks = 0, ndone = 0, bcnt = 0;
  int pc[2], hw[2];
  logic [1:0] prev, dat;
  exp_t sb[$];
  dda_multi_axis #(
    .N_AXES(2),
    .CMD_W(16),
    .CLK_DIV(2),
    .SLOTS(10)
`ifdef POS_COUNT_EN
    , .POS_W(32)
`endif
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_data(cmd_data),
    .cmd_wr(cmd_wr),
    .pulse(pulse),
    .dir(dir),
    .busy(busy),
    .period_done(period_done),
    .overrun(overrun),
    .sat_err(sat_err)
`ifdef POS_COUNT_EN
    , .pos(pos)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic int cnt_of(input int a);
    int m;
    m = a < 0 ? -a : a;
    return m > 10 ? 10 : m;
  endfunction
  task automatic step();
    exp_t e;
    @(negedge clk);
    bcnt += int'(busy);
    for (int i = 0; i < 2; i++) begin
      if (pulse[i] && !prev[i]) begin
        pc[i]++;
        dat[i] = dir[i];
      end
      if (pulse[i]) hw[i]++;
      else if (prev[i]) begin
        chk("pulse_width", hw[i], 2);
        hw[i] = 0;
      end
    end
    prev = pulse;
    if (period_done) begin
      ndone++;
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("count0", pc[0], e.c0);
        chk("count1", pc[1], e.c1);
        chk("dir0", dat[0], e.d0);
        chk("dir1", dat[1], e.d1);
      end
      pc = '{0, 0};
      dat = '0;
    end
  endtask
  task automatic wr(input int a0, input int a1);
    cmd_data = {16'(a1), 16'(a0)};
    cmd_wr = 1'b1;
    step();
    cmd_wr = 1'b0;
  endtask
  task automatic go(input int a0, input int a1);
    sb.push_back('{cnt_of(a0), cnt_of(a1), a0 < 0, a1 < 0});
    wr(a0, a1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      step();
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask
  task automatic clr_mon();
    prev = '0;
    dat = '0;
    hw = '{0, 0};
    pc = '{0, 0};
    sb.delete();
  endtask
  task automatic reset_dut();
    rst_n = 1'b0;
    clr_mon();
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask
  initial begin
    int d0, hits;
    rst_n = 1'b0;
    cmd_wr = 1'b0;
    cmd_data = '0;
    clr_mon();
    repeat (2) step();
    chk("rst_pulse", pulse, 0);
    chk("rst_dir", dir, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", period_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_sat", sat_err, 0);
    rst_n = 1'b1;
    step();
    bcnt = 0;
    d0 = ndone;
    go(3, 0);
    wait_idle();
    chk("busy_len", bcnt, 40);
    chk("one_done", ndone - d0, 1);
    chk("sat_clear", sat_err, 0);
    go(-10, 0);
    chk("dir_setup", dir[0], 1);
    wait_idle();
    chk("sat_exact", sat_err, 0);
    bcnt = 0;
    d0 = ndone;
    go(3, 0);
    repeat (39) step();
    go(2, 1);
    wait_idle();
    chk("edge_busy_len", bcnt, 80);
    chk("edge_done", ndone - d0, 2);
    chk("edge_overrun", overrun, 0);
    repeat (5) step();
    chk("edge_no_ghost", busy, 0);
    bcnt = 0;
    d0 = ndone;
    go(4, 0);
    repeat (10) step();
    go(6, 0);
    wait_idle();
    chk("b2b_busy_len", bcnt, 80);
    chk("b2b_done", ndone - d0, 2);
    chk("b2b_overrun", overrun, 0);
    bcnt = 0;
    go(4, 0);
    repeat (5) step();
    wr(6, 0);
    repeat (5) step();
    go(7, 0);
    chk("ovr_set", overrun, 1);
    wait_idle();
    chk("ovr_busy_len", bcnt, 80);
    chk("ovr_sticky", overrun, 1);
    go(25, 0);
    wait_idle();
    chk("sat_axis0", sat_err, 2'b01);
    go(2, -32768);
    wait_idle();
    chk("sat_both", sat_err, 2'b11);
    wr(-10, 3);
    repeat (22) step();
    chk("pre_rst_pulse", pulse, 2'b01);
    chk("pre_rst_dir", dir, 2'b01);
    chk("pre_rst_busy", busy, 1);
    #1 rst_n = 1'b0;
    clr_mon();
    #1;
    chk("async_pulse", pulse, 0);
    chk("async_dir", dir, 0);
    chk("async_busy", busy, 0);
    chk("async_sat", sat_err, 0);
    chk("async_overrun", overrun, 0);
    repeat (3) step();
    rst_n = 1'b1;
    hits = 0;
    d0 = ndone;
    repeat (20) begin
      step();
      hits += int'(busy | (|pulse) | (|dir) | period_done);
    end
    chk("post_rst_quiet", hits, 0);
    chk("post_rst_no_done", ndone - d0, 0);
`ifdef POS_COUNT_EN
    reset_dut();
    go(5, 0);
    wait_idle();
    go(-2, 0);
    wait_idle();
    chk("pos_net", pos[31:0], 3);
    reset_dut();
    go(-1, 0);
    wait_idle();
    chk("pos_wrap", pos[31:0], 32'hFFFF_FFFF);
`endif
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dda_multi_axis.md
Name: dda_multi_axis

Overview:
- Parametrised multi-axis DDA step/direction pulse generator. Next generation of the single-axis CPLD DDA.
- Each axis receives a signed per-period step count and spreads that many evenly spaced pulses across one control period.
- Synchronous command load with a shadow register allows back-to-back control periods without gaps. Sits between the MCU bus interface and the stepper/servo drivers.

Parameters:
- N_AXES, 3: number of independent axes.
- CMD_W, 16: width of each axis command, two's complement.
- CLK_DIV, 40: clk cycles per half step-slot (20 MHz with 40 gives a 4 us slot).
- SLOTS, 2500: step slots per control period (10 ms at 4 us).
- POS_W, 32: position counter width (optional feature only).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- cmd_data  in  N_AXES*CMD_W  packed signed step counts; axis i is bits [i*CMD_W +: CMD_W].
- cmd_wr  in  1  one-cycle load strobe, sampled on rising clk.
- pulse  out  N_AXES  step outputs.
- dir  out  N_AXES  direction outputs; 1 means negative.
- busy  out  1  high while a period is running.
- period_done  out  1  one-cycle strobe at the end of each period.
- overrun  out  1  sticky; the shadow register was overwritten before use.
- sat_err  out  N_AXES  sticky; the axis magnitude was clamped.
- pos  out  N_AXES*POS_W  signed position (only with POS_COUNT_EN; otherwise absent).

Behaviour:
- Reset, asynchronous:
  - pulse, dir, busy, period_done, overrun, sat_err all 0.
  - Accumulators, counters and shadow register cleared; pending flag cleared.
  - Asserting reset mid-period forces all outputs low immediately, with no completion pulse.
- States: IDLE, RUN.
- Command capture:
  - magnitude m_i = |cmd_i|, clamped to SLOTS. Any clamp sets sat_err[i].
  - sign s_i = cmd_i[CMD_W-1].
  - The most negative value is treated as magnitude 2^(CMD_W-1), then clamped.
- IDLE, cmd_wr=1:
  - Next cycle: busy=1, dir=s_i, acc_i=0, slot=0, div=0. State becomes RUN.
- Slot timing:
  - A slot is 2*CLK_DIV clks.
  - First half: pulse low.
  - At the half boundary: acc_i += m_i. If the result >= SLOTS, subtract SLOTS and drive pulse[i] high for the second half (CLK_DIV clks).
  - Accumulator width is clog2(2*SLOTS).
  - Result: exactly m_i pulses per period. Dir setup to the first pulse edge is >= CLK_DIV clks.
- Period end:
  - After SLOTS slots (SLOTS*2*CLK_DIV clks after busy rose), period_done=1 for one clk.
  - If pending: load the shadow into the active registers in that same cycle, update dir, reset acc, stay in RUN. busy stays high with no gap.
  - Else: busy=0 and state becomes IDLE.
- cmd_wr during RUN:
  - Captured into the shadow; pending=1.
  - If pending is already 1, the shadow is overwritten and overrun is set.
- cmd_wr coinciding with the period-end cycle: treated as a write in IDLE, so it starts the next period directly with no overrun.
- Sticky flags clear only on reset.
- m_i=0: no pulses, but the period still runs its full length.

Optional Feature:
- Macro POS_COUNT_EN.
- Defined:
  - pos port present.
  - pos_i increments (dir=0) or decrements (dir=1) on each pulse rising edge, two's complement wrap.
  - Cleared by reset only.
- Undefined: no pos port and no counter logic. All other behaviour identical.

Decomposition:
- Package dda_pkg: state enum (IDLE, RUN), slot-index and accumulator width functions (clog2-based), magnitude/clamp function.
- Sub-module dda_axis, instantiated N_AXES times: holds accumulator, active and shadow magnitude/sign, pulse/dir/sat_err, and the optional position counter.
- Top level: shared divider, slot counter, FSM, pending/overrun logic.

Test Plan (CLK_DIV=2, SLOTS=10, N_AXES=2 unless stated):
- cmd axis0=+3, axis1=0 -> axis0 gives 3 pulses, each 2 clks wide, dir0=0; axis1 silent. busy high 40 clks; one period_done.
- axis0=-10 -> 10 pulses (one per slot), dir0=1 set before the first pulse rising edge; sat_err=0.
- axis0=+25 -> clamped to 10 pulses; sat_err[0]=1 and stays set after busy falls.
- +4 written, then +6 written mid-period -> 4 pulses, then 6 with no idle clk between periods; two period_done; overrun=0. A third write before the boundary sets overrun and uses the last value.
- rst_n low at slot 5 -> pulse/dir/busy 0 within the same clk. After release, outputs stay 0 until a new cmd_wr.
- POS_COUNT_EN: +5 period, then -2 period -> pos0 = 3. Start from 0 with -1 -> pos0 = all ones (wrap).
